cluster_sequencer: RTL and testbench

Single-clock controller that sweeps the four core clusters of the die one at a time. For each enabled cluster it loads a per-cluster seed through that cluster's reset, lets it run for a fixed number of cycles, and captures its 8-bit output. Each capture is returned through a valid/ready result port. The block sits between the top-level I/O and the cluster array, replacing free-running XOR mixing with sequenced, observable per-cluster results.

---
 rtl/cluster_seq_pkg.sv | 30 +++
 rtl/cluster_sequencer_if.sv | 30 +++
 rtl/cluster_rr_pick.sv | 30 +++
 rtl/cluster_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cluster_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_seq_pkg.sv
// Package: cluster_seq_pkg
// Shared types and helpers for the cluster sequencer.
//   seq_state_t      - sequencer FSM states
//   DEF_NUM_CLUSTERS - default number of clusters swept
//   DEF_SEED_STRIDE  - default seed offset between consecutive clusters
//   ID_W             - width of a cluster index (result_id)
//   cluster_seed()   - seed presented to cluster idx, modulo 256
package cluster_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_CLUSTERS = 4;
    localparam int DEF_SEED_STRIDE  = 16;
    localparam int ID_W             = 2;

    // Only the low byte of the product matters because the seed wraps at 256.
    function automatic logic [7:0] cluster_seed(input logic [7:0]      base,
                                                input logic [ID_W-1:0] idx,
                                                input int              stride);
        int prod;
        prod = stride * int'(idx);
        return base + prod[7:0];
    endfunction

endpackage

// File: rtl/cluster_sequencer_if.sv
// Interface: cluster_sequencer_if
// Valid/ready result channel carrying one captured cluster output.
//   result       - captured 8-bit cluster output
//   result_id    - index of the cluster that produced result
//   result_valid - result/result_id are meaningful
//   result_ready - consumer accepts the result this cycle
// Modports: master (sequencer side), slave (consumer side).
interface cluster_sequencer_if;
    import cluster_seq_pkg::*;

    logic [7:0]      result;
    logic [ID_W-1:0] result_id;
    logic            result_valid;
    logic            result_ready;

    modport master (
        output result,
        output result_id,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_id,
        input  result_valid,
        output result_ready
    );

endinterface

// File: rtl/cluster_rr_pick.sv
// Module: cluster_rr_pick
// Combinational upward search for the next enabled cluster.
//   mask     - cluster enable mask
//   cur      - current index, signed; -1 requests the first enabled cluster
//   next_idx - lowest set index strictly above cur (0 when none)
//   found    - a higher set index exists
module cluster_rr_pick
    import cluster_seq_pkg::*;
#(
    parameter int NUM_CLUSTERS = DEF_NUM_CLUSTERS
) (
    input  logic [NUM_CLUSTERS-1:0] mask,
    input  logic signed [ID_W:0]    cur,
    output logic [ID_W-1:0]         next_idx,
    output logic                    found
);

    // The search never wraps: a sweep visits each enabled cluster once, upward.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            if (!found && mask[i] && (i > int'(cur))) begin
                next_idx = ID_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cluster_sequencer.sv
// Module: cluster_sequencer
// Sweeps the enabled clusters one at a time: loads a per-cluster seed while
// the cluster is held in reset, releases it for RUN_CYCLES cycles, captures its
// 8-bit output and returns it on a valid/ready result channel.
// Optional feature macro: CLUSTER_SEQ_CHECKSUM_EN (XOR checksum of the sweep).
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start        - sweep request, honoured only in IDLE
//   seed, mask   - global seed and cluster enable mask, latched on start
//   cl_data      - flattened cluster outputs, cluster i at [8i+7:8i]
//   cl_rst_n     - per-cluster active-low reset/gate
//   cl_seed      - seed presented to the clusters
//   busy, done   - sweep in progress / one-cycle end-of-sweep pulse
//   checksum     - XOR of all results of the sweep (0 when feature disabled)
//   res          - result channel (master side)
module cluster_sequencer
    import cluster_seq_pkg::*;
#(
    parameter int NUM_CLUSTERS = DEF_NUM_CLUSTERS,
    parameter int RUN_CYCLES   = 16,
    parameter int SEED_STRIDE  = DEF_SEED_STRIDE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                seed,
    input  logic [NUM_CLUSTERS-1:0]   mask,
    input  logic [8*NUM_CLUSTERS-1:0] cl_data,
    output logic [NUM_CLUSTERS-1:0]   cl_rst_n,
    output logic [7:0]                cl_seed,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                checksum,
    cluster_sequencer_if.master       res
);

    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    seq_state_t              state;
    logic [NUM_CLUSTERS-1:0] mask_q;
    logic [7:0]              seed_q;
    logic [ID_W-1:0]         sel;
    logic [CNT_W-1:0]        cnt;
    logic                    last_run;

    logic [7:0]              cl_word [NUM_CLUSTERS];
    logic [ID_W-1:0]         first_idx;
    logic                    first_found;
    logic [ID_W-1:0]         next_idx;
    logic                    next_found;

    for (genvar g = 0; g < NUM_CLUSTERS; g++) begin : g_word
        assign cl_word[g] = cl_data[8*g +: 8];
    end

    // First pick looks at the live mask input so LOAD can start right after
    // the accepting edge, before mask_q is visible.
    cluster_rr_pick #(.NUM_CLUSTERS(NUM_CLUSTERS)) u_first_pick (
        .mask     (mask),
        .cur      ({(ID_W+1){1'b1}}),
        .next_idx (first_idx),
        .found    (first_found)
    );

    cluster_rr_pick #(.NUM_CLUSTERS(NUM_CLUSTERS)) u_next_pick (
        .mask     (mask_q),
        .cur      ({1'b0, sel}),
        .next_idx (next_idx),
        .found    (next_found)
    );

    assign last_run = (cnt == CNT_W'(RUN_CYCLES - 1));

    // Outputs are registered, so each transition writes the values that the
    // destination state presents (cl_seed for LOAD, the one-hot gate for RUN).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            mask_q           <= '0;
            seed_q           <= '0;
            sel              <= '0;
            cnt              <= '0;
            cl_rst_n         <= '0;
            cl_seed          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            res.result       <= '0;
            res.result_id    <= '0;
            res.result_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q <= seed;
                        mask_q <= mask;
                        if (first_found) begin
                            sel     <= first_idx;
                            cl_seed <= cluster_seed(seed, first_idx, SEED_STRIDE);
                            busy    <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    cl_rst_n <= NUM_CLUSTERS'(1) << sel;
                    cnt      <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    if (last_run) begin
                        res.result       <= cl_word[sel];
                        res.result_id    <= sel;
                        res.result_valid <= 1'b1;
                        cl_rst_n         <= '0;
                        state            <= OUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OUT: begin
                    if (res.result_ready) begin
                        res.result_valid <= 1'b0;
                        if (next_found) begin
                            sel     <= next_idx;
                            cl_seed <= cluster_seed(seed_q, next_idx, SEED_STRIDE);
                            state   <= LOAD;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLUSTER_SEQ_CHECKSUM_EN
    logic [7:0] checksum_q;

    // Accumulates at capture time, so the value is final by the time done pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (state == IDLE && start) begin
            checksum_q <= '0;
        end else if (state == RUN && last_run) begin
            checksum_q <= checksum_q ^ cl_word[sel];
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_cluster_sequencer.sv
// Testbench: tb_cluster_sequencer
// Scoreboard bench for cluster_sequencer. Each cluster is modelled as a byte
// register that loads cl_seed while gated and steps x -> 5x+1 while released.
// A sweep's expected results are derived from the seed/mask rules and queued;
// a negedge monitor pops and compares at every result handshake.
module tb_cluster_sequencer;

    localparam int NC         = 4;
    localparam int RUN_CYCLES = 16;
    localparam int STRIDE     = 16;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      seed = 8'h00;
    logic [NC-1:0]   mask = '0;
    logic [8*NC-1:0] cl_data;
    logic [NC-1:0]   cl_rst_n;
    logic [7:0]      cl_seed;
    logic            busy;
    logic            done;
    logic [7:0]      checksum;

    cluster_sequencer_if res_if ();

    always #5 clk = ~clk;

    cluster_sequencer #(
        .NUM_CLUSTERS (NC),
        .RUN_CYCLES   (RUN_CYCLES),
        .SEED_STRIDE  (STRIDE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .seed     (seed),
        .mask     (mask),
        .cl_data  (cl_data),
        .cl_rst_n (cl_rst_n),
        .cl_seed  (cl_seed),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .res      (res_if)
    );

    // Cluster array model
    logic [7:0] cl_st [NC];

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (!cl_rst_n[i]) cl_st[i] <= cl_seed;
            else              cl_st[i] <= cl_st[i] * 8'd5 + 8'd1;
        end
    end

    assign cl_data = {cl_st[3], cl_st[2], cl_st[1], cl_st[0]};

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         done_count = 0;
    exp_t       sb[$];
    logic [7:0] exp_ck = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A released cluster steps once per cycle; capture sees RUN_CYCLES-1 steps.
    function automatic logic [7:0] cluster_model(input logic [7:0] s);
        logic [7:0] x;
        x = s;
        for (int k = 0; k < RUN_CYCLES - 1; k++) x = x * 8'd5 + 8'd1;
        return x;
    endfunction

    task automatic pushSweep(input logic [7:0] s, input logic [NC-1:0] m);
        exp_t       e;
        logic [7:0] ck;
        ck = 8'h00;
        for (int i = 0; i < NC; i++) begin
            if (m[i]) begin
                e.id   = 2'(i);
                e.data = cluster_model(s + 8'(STRIDE * i));
                sb.push_back(e);
                ck ^= e.data;
            end
        end
`ifdef CLUSTER_SEQ_CHECKSUM_EN
        exp_ck = ck;
`else
        exp_ck = 8'h00;
`endif
    endtask

    // Drives a start; returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [7:0] s, input logic [NC-1:0] m);
        start = 1'b1;
        seed  = s;
        mask  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        pushSweep(s, m);
    endtask

    // Waits for done; optionally randomises ready and throws ignored starts.
    task automatic waitDone(input bit rnd, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (rnd) begin
                res_if.result_ready = 1'($urandom_range(0, 1));
                start               = ($urandom_range(0, 3) == 0);
                seed                = 8'($urandom);
                mask                = NC'($urandom);
            end
            @(posedge clk);
            #1;
        end
        if (!seen && done) seen = 1'b1;
        start = 1'b0;
        res_if.result_ready = 1'b1;
        checkOutput("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"},     32'(busy), 32'd0);
        checkOutput({tag, "_done"},     32'(done), 32'd0);
        checkOutput({tag, "_valid"},    32'(res_if.result_valid), 32'd0);
        checkOutput({tag, "_result"},   32'(res_if.result), 32'd0);
        checkOutput({tag, "_id"},       32'(res_if.result_id), 32'd0);
        checkOutput({tag, "_cl_seed"},  32'(cl_seed), 32'd0);
        checkOutput({tag, "_cl_rst_n"}, 32'(cl_rst_n), 32'd0);
        checkOutput({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    // Monitor: result handshakes, backpressure stability, done properties
    logic       hold_flag = 1'b0;
    logic [7:0] hold_res;
    logic [1:0] hold_id;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_flag <= 1'b0;
        end else begin
            if (hold_flag) begin
                checkOutput("hold_valid",  32'(res_if.result_valid), 32'd1);
                checkOutput("hold_result", 32'(res_if.result), 32'(hold_res));
                checkOutput("hold_id",     32'(res_if.result_id), 32'(hold_id));
            end
            if (res_if.result_valid && res_if.result_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 32'd1, 32'd0);
                end else begin
                    checkOutput("result",    32'(res_if.result), 32'(sb[0].data));
                    checkOutput("result_id", 32'(res_if.result_id), 32'(sb[0].id));
                    void'(sb.pop_front());
                end
            end
            hold_flag <= res_if.result_valid && !res_if.result_ready;
            hold_res  <= res_if.result;
            hold_id   <= res_if.result_id;
            if (done) begin
                checkOutput("done_no_valid", 32'(res_if.result_valid), 32'd0);
                checkOutput("done_busy",     32'(busy), 32'd0);
                checkOutput("done_sb_empty", 32'(sb.size()), 32'd0);
                checkOutput("done_checksum", 32'(checksum), 32'(exp_ck));
                done_count <= done_count + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int d0;

        res_if.result_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single cluster: LOAD values, result latency, done one cycle later
        $display("[TB] single cluster");
        applyStimulus(8'h00, 4'b0001);
        checkOutput("single_load_seed", 32'(cl_seed), 32'h00);
        checkOutput("single_load_rst",  32'(cl_rst_n), 32'h0);
        checkOutput("single_busy",      32'(busy), 32'd1);
        n = 0;
        while (!res_if.result_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("single_valid_latency", 32'(n), 32'(RUN_CYCLES + 1));
        @(posedge clk);
        #1;
        checkOutput("single_done",      32'(done), 32'd1);
        checkOutput("single_busy_clr",  32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("single_done_fall", 32'(done), 32'd0);

        // Seed wrap and single-bit gate release
        $display("[TB] seed wrap");
        applyStimulus(8'hF8, 4'b0010);
        checkOutput("wrap_load_seed", 32'(cl_seed), 32'h08);
        checkOutput("wrap_load_rst",  32'(cl_rst_n), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("wrap_run_rst",   32'(cl_rst_n), 32'b0010);
        waitDone(1'b0, 200);

        // Sparse sweep: busy length and a single done
        $display("[TB] sparse sweep");
        @(posedge clk);
        #1;
        d0 = done_count;
        applyStimulus(8'h3C, 4'b1010);
        n = 0;
        while (busy && n < 500) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("sparse_busy_cycles", 32'(n), 32'(2 * (RUN_CYCLES + 2)));
        checkOutput("sparse_done_at_end", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("sparse_done_count", 32'(done_count - d0), 32'd1);

        // Backpressure in OUT with ignored start pulses
        $display("[TB] backpressure");
        res_if.result_ready = 1'b0;
        applyStimulus(8'h77, 4'b0101);
        n = 0;
        while (!res_if.result_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("bp_valid_seen", 32'(res_if.result_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            start = 1'b1;
            seed  = 8'($urandom);
            mask  = 4'hF;
            checkOutput("bp_no_load_rst",  32'(cl_rst_n), 32'h0);
            checkOutput("bp_no_load_seed", 32'(cl_seed), 32'h77);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        res_if.result_ready = 1'b1;
        waitDone(1'b0, 300);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_no_restart", 32'(busy), 32'd0);

        // Empty mask
        $display("[TB] empty mask");
        applyStimulus(8'h55, 4'b0000);
        checkOutput("empty_done",      32'(done), 32'd1);
        checkOutput("empty_busy",      32'(busy), 32'd0);
        checkOutput("empty_valid",     32'(res_if.result_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("empty_done_fall", 32'(done), 32'd0);
        checkOutput("empty_busy_late", 32'(busy), 32'd0);

        // Random back-to-back sweeps with random ready and stray starts
        $display("[TB] random sweeps");
        for (int r = 0; r < 25; r++) begin
            applyStimulus(8'($urandom), NC'($urandom));
            waitDone(1'b1, 1500);
        end

        // Mid-sweep reset during RUN of cluster 2
        $display("[TB] mid-sweep reset");
        @(posedge clk);
        #1;
        applyStimulus(8'hA0, 4'b1111);
        n = 0;
        while (cl_rst_n != 4'b0100 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("midrst_reach_c2", 32'(cl_rst_n), 32'b0100);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkReset("midrst");
        sb.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full sweep; checksum is the XOR of all four results when enabled
        $display("[TB] full sweep checksum");
        applyStimulus(8'h5A, 4'b1111);
        waitDone(1'b0, 500);
        checkOutput("full_checksum", 32'(checksum), 32'(exp_ck));
        @(posedge clk);
        #1;
        checkOutput("full_checksum_hold", 32'(checksum), 32'(exp_ck));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
